// File: rtl/demux_dispatch_pkg.sv
// Shared types and constants for the round-robin burst dispatcher.
// State encoding, channel count and select width live here.
package demux_dispatch_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    XFER = 2'd2
  } state_t;

  function automatic logic [NUM_CH-1:0] onehot(
    input logic [SEL_W-1:0] s
  );
    onehot = NUM_CH'(1) << s;
  endfunction

endpackage

// File: rtl/demux_dispatch_pick.sv
// rr_pick4: first enabled channel strictly after last, wrapping.
// Purely combinational; found is low only when en is zero.
module rr_pick4
  import demux_dispatch_pkg::*;
(
  input  logic [NUM_CH-1:0] en,
  input  logic [SEL_W-1:0]  last,
  output logic [SEL_W-1:0]  next,
  output logic              found
);

  logic [SEL_W-1:0] idx;

  // Walk offsets 4..1 so the nearest enabled channel wins last.
  always_comb begin
    next  = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = NUM_CH; i >= 1; i--) begin
      idx = last + SEL_W'(i);
      if (en[idx]) begin
        next  = idx;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/demux_dispatch.sv
// Round-robin burst dispatcher: one upstream stream, four channels.
// Owns the demux select and the per-channel valid/ready gating.
module demux_dispatch
  import demux_dispatch_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en,
  input  logic [WIDTH-1:0]  in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [NUM_CH-1:0] out_valid,
  input  logic [NUM_CH-1:0] out_ready,
  output logic [SEL_W-1:0]  sel,
  output logic              busy
);

  localparam logic [3:0] LAST_CNT = 4'(BURST - 1);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] last_q, last_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [SEL_W-1:0] pick;
  logic             found;
  logic             xfer;
  logic             beat;

  rr_pick4 u_pick (
    .en    (en),
    .last  (last_q),
    .next  (pick),
    .found (found)
  );

  // Handshake is gated by rst so no word moves in a reset cycle.
  assign xfer      = (state_q == XFER) && !rst;
  assign in_ready  = xfer && out_ready[sel_q];
  assign out_valid = (xfer && in_valid) ? onehot(sel_q) : '0;
  assign beat      = in_valid && in_ready;
  assign out_data  = in_data;
  assign sel       = sel_q;
  assign busy      = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid && |en) state_d = ARB;
      end
      ARB: begin
        if (found) begin
          sel_d   = pick;
          last_d  = pick;
          cnt_d   = '0;
          state_d = XFER;
        end else begin
          state_d = IDLE;
        end
      end
      XFER: begin
        if (beat) begin
          cnt_d = cnt_q + 4'd1;
          if (in_last || cnt_q == LAST_CNT) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      last_q  <= 2'd3;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: doc/demux_dispatch.md
# demux_dispatch

Round-robin burst dispatcher sharing one input stream among four output channels. It owns and drives the select of the 1-to-4 demux datapath and gates each channel with a valid/ready handshake. Each grant carries a burst of up to BURST words; channels are skipped when disabled by configuration. It sits between a single upstream producer and four downstream consumers.

## Interface
Parameters:
- WIDTH, 8, data word width.
- BURST, 4, maximum words per grant; legal 1..16.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  4  per-channel enable; bit k allows channel k to be granted.
- in_data  in  WIDTH  upstream word.
- in_valid  in  1  upstream word present.
- in_last  in  1  qualifies in_data; ends the current burst early.
- in_ready  out  1  dispatcher accepts in_data this cycle.
- out_data  out  WIDTH  shared downstream bus; equals in_data combinationally.
- out_valid  out  4  one-hot; bit sel is high when a word is offered to that channel.
- out_ready  in  4  per-channel downstream ready.
- sel  out  2  registered demux select; the currently granted channel.
- busy  out  1  high in ARB and XFER.

## Operation
- States: IDLE, ARB, XFER.
- IDLE -> ARB when in_valid && |en. Otherwise stay in IDLE.
- ARB: pick the first enabled channel strictly after last_ch in order 0,1,2,3 (wrapping). Load sel with it, set last_ch to it, clear burst_cnt, and go to XFER.
  - If en is 0 in ARB, return to IDLE with sel unchanged.
- XFER:
  - out_valid[sel] = in_valid; all other out_valid bits are 0.
  - in_ready = out_ready[sel].
  - A beat occurs when in_valid && in_ready.
  - On a beat, burst_cnt increments.
  - If a beat has in_last=1 or burst_cnt==BURST-1, go to IDLE.
- In IDLE and ARB, in_ready=0 and out_valid=0.
- en is sampled only in ARB. Deasserting en[sel] during XFER does not stop the burst; the burst completes.
- out_ready of non-granted channels is ignored.
- Words are never duplicated or dropped. Each beat transfers exactly one word to exactly one channel.
- burst_cnt is 4 bits and never wraps. The BURST-1 comparison terminates the burst first.
- With BURST=1, every beat ends its burst.

## Timing
- Reset values: state=IDLE, sel=0, last_ch=3 (so the first grant goes to channel 0 when enabled), burst_cnt=0, in_ready=0, out_valid=0, busy=0.
- Reset asserted in XFER: the next edge forces IDLE. The in-flight word is not transferred if rst is high in that cycle; in_ready and out_valid are gated low while rst=1.
- Grant latency: in_valid rising in IDLE at cycle t gives ARB at t+1 and the first beat possible at t+2.
- Between consecutive bursts there are two bubble cycles (IDLE, ARB), including when in_valid stays high.
- Throughput within a burst is one word per cycle while out_ready[sel]=1.
- in_ready and out_valid are combinational from state, sel, in_valid and out_ready. There is no combinational path from en to any output.
- Upstream must hold in_data, in_valid and in_last stable until the beat.

## Structure
- Package demux_dispatch_pkg holds:
  - State encoding constants: IDLE=2'd0, ARB=2'd1, XFER=2'd2.
  - NUM_CH=4.
  - Select width 2.
- Sub-module rr_pick4 (combinational): inputs en[3:0] and last[1:0]; outputs next[1:0] and found. Used in ARB.
- The existing demux datapath is instantiated by the integrator, driven by sel. out_valid is produced here one-hot, matching the demux routing.

## Test plan
- Reset, then en=4'b1111, continuous valid, all ready, BURST=4, no in_last: bursts of 4 words go to channels 0,1,2,3,0; exactly 2 idle cycles between bursts; words arrive in order.
- en=4'b0101, sustained traffic: grants alternate 0,2,0,2; out_valid[1] and out_valid[3] never assert.
- in_last on the 2nd word of a grant to channel 1: the burst ends after 2 words and the next grant goes to channel 2.
- out_ready[sel] held low for 3 cycles mid-burst: in_ready stays low, out_data and out_valid hold, no beat counted, and the burst resumes with its remaining count.
- Clearing en[sel] during XFER: the current burst completes its 4 words and that channel is skipped at the next ARB.
- rst pulsed during the 3rd beat of a burst: the next cycle shows state IDLE, sel=0 and outputs 0, and the first post-reset grant goes to channel 0.
